// File: rtl/led_frame_streamer_pkg.sv
// Shared definitions for the LED frame path: memory geometry, streamer states
// and the default WS2812 timing for the board clock.
package led_frame_streamer_pkg;

    localparam int MEM_ADDR_W = 9;
    localparam int MEM_DATA_W = 8;

    // 48 MHz board clock: 1.25 us bit, 0.35 us / 0.73 us high, 62.5 us latch
    localparam int DEF_NUM_BYTES    = 72;
    localparam int DEF_BIT_CYCLES   = 60;
    localparam int DEF_T0H_CYCLES   = 17;
    localparam int DEF_T1H_CYCLES   = 35;
    localparam int DEF_LATCH_CYCLES = 3000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } stream_state_t;

    function automatic int high_cycles(input logic bit_value, input int t0h, input int t1h);
        return bit_value ? t1h : t0h;
    endfunction

endpackage

// File: rtl/led_frame_streamer_ws_bit_encoder.sv
// One-wire bit encoder: a bit_start strobe launches one BIT_CYCLES-long bit
// period whose high time depends on the bit value; bit_end marks its last cycle.
module led_frame_streamer_ws_bit_encoder
    import led_frame_streamer_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int T0H_CYCLES = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES = DEF_T1H_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic bit_start,
    input  logic bit_value,
    output logic led_data,
    output logic bit_end
);

    localparam int CNT_W = $clog2(BIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [CNT_W-1:0] bit_cnt_r;
    logic [CNT_W-1:0] next_cnt_s;
    logic [CNT_W-1:0] high_cnt_s;
    logic             active_r;
    logic             value_r;
    logic             led_r;
    logic             bit_end_s;

    // Derive the high time of the current bit and the end-of-period flag
    always_comb begin
        high_cnt_s = CNT_W'(high_cycles(value_r, T0H_CYCLES, T1H_CYCLES));
        next_cnt_s = bit_cnt_r + ONE_CNT;
        bit_end_s  = active_r && (bit_cnt_r == LAST_CNT);
    end

    // Bit period counter and registered line level; a new start wins over bit end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt_r <= {CNT_W{1'b0}};
            active_r  <= 1'b0;
            value_r   <= 1'b0;
            led_r     <= 1'b0;
        end else if (bit_start) begin
            bit_cnt_r <= {CNT_W{1'b0}};
            active_r  <= 1'b1;
            value_r   <= bit_value;
            led_r     <= 1'b1;
        end else if (bit_end_s) begin
            bit_cnt_r <= {CNT_W{1'b0}};
            active_r  <= 1'b0;
            led_r     <= 1'b0;
        end else if (active_r) begin
            bit_cnt_r <= next_cnt_s;
            led_r     <= (next_cnt_s < high_cnt_s);
        end else begin
            led_r     <= 1'b0;
        end
    end

    assign led_data = led_r;
    assign bit_end  = bit_end_s;

endmodule

// File: rtl/led_frame_streamer.sv
// Frame reader: fetches NUM_BYTES from the frame memory with one-byte prefetch
// and streams them MSB-first onto the LED line, followed by the latch gap.
module led_frame_streamer
    import led_frame_streamer_pkg::*;
#(
    parameter int NUM_BYTES    = DEF_NUM_BYTES,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  perform_read,
    output logic [MEM_ADDR_W-1:0] read_address,
    input  logic [MEM_DATA_W-1:0] read_data,
    input  logic                  read_data_ready,
    output logic                  led_data
);

    localparam int LCNT_W = $clog2(LATCH_CYCLES + 1);
    localparam logic [MEM_ADDR_W-1:0] LAST_BYTE  = MEM_ADDR_W'(NUM_BYTES - 1);
    localparam logic [MEM_ADDR_W-1:0] ONE_ADDR   = MEM_ADDR_W'(1);
    localparam logic [LCNT_W-1:0]     LAST_LATCH = LCNT_W'(LATCH_CYCLES - 1);
    localparam logic [LCNT_W-1:0]     ONE_LATCH  = LCNT_W'(1);

    stream_state_t         state_r;
    stream_state_t         state_s;
    logic [MEM_ADDR_W-1:0] byte_idx_r;
    logic [MEM_ADDR_W-1:0] next_idx_s;
    logic [MEM_ADDR_W-1:0] fetch_addr_s;
    logic [MEM_ADDR_W-1:0] read_address_r;
    logic [2:0]            bit_idx_r;
    logic [MEM_DATA_W-1:0] shift_r;
    logic [MEM_DATA_W-1:0] next_byte_r;
    logic [LCNT_W-1:0]     latch_cnt_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  perform_read_r;
    logic                  bit_start_s;
    logic                  bit_value_s;
    logic                  bit_end_s;
    logic                  fetch_s;
    logic                  last_byte_s;
    logic                  latch_end_s;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, bit launches and memory fetch requests
    always_comb begin
        state_s      = state_r;
        bit_start_s  = 1'b0;
        bit_value_s  = 1'b0;
        fetch_s      = 1'b0;
        fetch_addr_s = {MEM_ADDR_W{1'b0}};
        next_idx_s   = byte_idx_r + ONE_ADDR;
        last_byte_s  = (byte_idx_r == LAST_BYTE);
        latch_end_s  = (state_r == ST_LATCH) && (latch_cnt_r == LAST_LATCH);
        case (state_r)
            ST_IDLE: begin
                // a start landing on the done cycle is dropped on purpose
                if (start && !done_r) begin
                    state_s = ST_PRIME;
                    fetch_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRIME: begin
                if (read_data_ready) begin
                    state_s      = ST_SEND;
                    bit_start_s  = 1'b1;
                    bit_value_s  = read_data[MEM_DATA_W-1];
                    fetch_s      = (LAST_BYTE != {MEM_ADDR_W{1'b0}});
                    fetch_addr_s = ONE_ADDR;
                end else begin
                    state_s = ST_PRIME;
                end
            end
            ST_SEND: begin
                if (!bit_end_s) begin
                    state_s = ST_SEND;
                end else if (bit_idx_r != 3'd0) begin
                    bit_start_s = 1'b1;
                    bit_value_s = shift_r[MEM_DATA_W-2];
                end else if (last_byte_s) begin
                    state_s = ST_LATCH;
                end else begin
                    bit_start_s  = 1'b1;
                    bit_value_s  = next_byte_r[MEM_DATA_W-1];
                    fetch_s      = (next_idx_s < LAST_BYTE);
                    fetch_addr_s = next_idx_s + ONE_ADDR;
                end
            end
            ST_LATCH: begin
                if (latch_end_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LATCH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Byte/bit bookkeeping, shift register, prefetch buffer and latch timer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_idx_r  <= {MEM_ADDR_W{1'b0}};
            bit_idx_r   <= 3'd0;
            shift_r     <= {MEM_DATA_W{1'b0}};
            next_byte_r <= {MEM_DATA_W{1'b0}};
            latch_cnt_r <= {LCNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_PRIME: begin
                    if (read_data_ready) begin
                        shift_r    <= read_data;
                        byte_idx_r <= {MEM_ADDR_W{1'b0}};
                        bit_idx_r  <= 3'd7;
                    end
                    latch_cnt_r <= {LCNT_W{1'b0}};
                end
                ST_SEND: begin
                    if (read_data_ready) begin
                        next_byte_r <= read_data;
                    end
                    if (bit_end_s && (bit_idx_r != 3'd0)) begin
                        shift_r   <= {shift_r[MEM_DATA_W-2:0], 1'b0};
                        bit_idx_r <= bit_idx_r - 3'd1;
                    end else if (bit_end_s && !last_byte_s) begin
                        shift_r    <= next_byte_r;
                        byte_idx_r <= next_idx_s;
                        bit_idx_r  <= 3'd7;
                    end
                    latch_cnt_r <= {LCNT_W{1'b0}};
                end
                ST_LATCH: begin
                    latch_cnt_r <= latch_end_s ? {LCNT_W{1'b0}} : (latch_cnt_r + ONE_LATCH);
                end
                default: begin
                    latch_cnt_r <= {LCNT_W{1'b0}};
                end
            endcase
        end
    end

    // Registered status and memory port outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            perform_read_r <= 1'b0;
            read_address_r <= {MEM_ADDR_W{1'b0}};
        end else begin
            busy_r         <= (state_s != ST_IDLE);
            done_r         <= latch_end_s;
            perform_read_r <= fetch_s;
            if (fetch_s) begin
                read_address_r <= fetch_addr_s;
            end
        end
    end

    led_frame_streamer_ws_bit_encoder #(
        .BIT_CYCLES (BIT_CYCLES),
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES)
    ) u_bit_encoder (
        .clock     (clock),
        .reset     (reset),
        .bit_start (bit_start_s),
        .bit_value (bit_value_s),
        .led_data  (led_data),
        .bit_end   (bit_end_s)
    );

    assign busy         = busy_r;
    assign done         = done_r;
    assign perform_read = perform_read_r;
    assign read_address = read_address_r;

endmodule

// File: tb/tb_led_frame_streamer.sv
// Bench for led_frame_streamer: 3-byte and 1-byte instances with 1-cycle
// memory models; expected bit high-times and read addresses are queued per frame.
module tb_led_frame_streamer;

    localparam int BIT_C = 8;
    localparam int T0H   = 2;
    localparam int T1H   = 5;
    localparam int LATCH = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       start_a = 1'b0, busy_a, done_a, pr_a, rdy_a, led_a;
    logic [8:0] addr_a;
    logic [7:0] rd_a;
    logic [7:0] mem_a [0:3];

    logic       start_b = 1'b0, busy_b, done_b, pr_b, rdy_b, led_b;
    logic [8:0] addr_b;
    logic [7:0] rd_b;
    logic [7:0] mem_b;

    int         tests_run = 0;
    int         failed = 0;
    int         exp_hi [$];
    logic [8:0] exp_addr [$];

    led_frame_streamer #(.NUM_BYTES(3), .BIT_CYCLES(BIT_C), .T0H_CYCLES(T0H),
                         .T1H_CYCLES(T1H), .LATCH_CYCLES(LATCH)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .perform_read(pr_a), .read_address(addr_a), .read_data(rd_a),
        .read_data_ready(rdy_a), .led_data(led_a));

    led_frame_streamer #(.NUM_BYTES(1), .BIT_CYCLES(BIT_C), .T0H_CYCLES(T0H),
                         .T1H_CYCLES(T1H), .LATCH_CYCLES(LATCH)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .perform_read(pr_b), .read_address(addr_b), .read_data(rd_b),
        .read_data_ready(rdy_b), .led_data(led_b));

    // Frame memories with one-cycle read latency
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            rdy_a <= 1'b0; rd_a <= 8'h00;
            rdy_b <= 1'b0; rd_b <= 8'h00;
        end else begin
            rdy_a <= pr_a; rd_a <= mem_a[addr_a[1:0]];
            rdy_b <= pr_b; rd_b <= mem_b;
        end
    end

    task automatic push_frame(input bit sel);
        logic [7:0] v;
        int nbytes;
        nbytes = sel ? 1 : 3;
        for (int b = 0; b < nbytes; b++) begin
            v = sel ? mem_b : mem_a[b];
            exp_addr.push_back(9'(b));
            for (int i = 7; i >= 0; i--) exp_hi.push_back(v[i] ? T1H : T0H);
        end
    endtask

    // Starts a frame and scores it cycle by cycle; k counts negedges after the start edge.
    task automatic watch(input bit sel, input int window, input bit stop_at_done,
                         input int inj_k, input bit inj_on_done);
        int nbytes, hi_len, first_rise, last_rise, done_cnt, done_k, exp_v, exp_done;
        logic led, led_prev, pr, pr_prev, dn, bsy;
        logic [8:0] ad, ea;
        nbytes = sel ? 1 : 3;
        exp_done = 3 + nbytes * 8 * BIT_C + LATCH;
        hi_len = 0; first_rise = -1; last_rise = -1; done_cnt = 0; done_k = -1;
        led_prev = 1'b0; pr_prev = 1'b0;
        @(negedge clock);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        for (int k = 1; k <= window; k++) begin
            @(negedge clock);
            start_a = 1'b0; start_b = 1'b0;
            if (k == inj_k) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            led = sel ? led_b : led_a;
            pr  = sel ? pr_b : pr_a;
            ad  = sel ? addr_b : addr_a;
            dn  = sel ? done_b : done_a;
            bsy = sel ? busy_b : busy_a;
            if (k == 1) begin
                tests_run++;
                if (pr !== 1'b1 || bsy !== 1'b1 || ad !== 9'd0) begin
                    failed++;
                    $display("FAIL latency k=1: perform_read=%b busy=%b addr=%0d required 1 1 0", pr, bsy, ad);
                end
            end
            if (led === 1'b1 && led_prev !== 1'b1) begin
                if (first_rise < 0) begin
                    first_rise = k;
                end else begin
                    tests_run++;
                    if (k - last_rise !== BIT_C) begin
                        failed++;
                        $display("FAIL bit_period at k=%0d: got %0d required %0d", k, k - last_rise, BIT_C);
                    end
                end
                last_rise = k;
                hi_len = 0;
            end
            if (led === 1'b1) hi_len++;
            if (led !== 1'b1 && led_prev === 1'b1) begin
                tests_run++;
                if (exp_hi.size() == 0) begin
                    failed++;
                    $display("FAIL extra_bit at k=%0d: high %0d cycles, none expected", k, hi_len);
                end else begin
                    exp_v = exp_hi.pop_front();
                    if (hi_len !== exp_v) begin
                        failed++;
                        $display("FAIL high_time at k=%0d: got %0d required %0d", k, hi_len, exp_v);
                    end
                end
            end
            if (pr === 1'b1) begin
                tests_run++;
                if (pr_prev === 1'b1) begin
                    failed++;
                    $display("FAIL read_strobe_width at k=%0d: high 2 cycles, required 1", k);
                end else if (exp_addr.size() == 0) begin
                    failed++;
                    $display("FAIL extra_read at k=%0d: address %0d, none expected", k, ad);
                end else begin
                    ea = exp_addr.pop_front();
                    if (ad !== ea) begin
                        failed++;
                        $display("FAIL read_address at k=%0d: got %0d required %0d", k, ad, ea);
                    end
                end
            end
            if (dn === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
                if (inj_on_done) begin
                    if (sel) start_b = 1'b1; else start_a = 1'b1;
                end
            end
            led_prev = led;
            pr_prev = pr;
            if (stop_at_done && dn === 1'b1) break;
        end
        start_a = 1'b0; start_b = 1'b0;
        tests_run++;
        if (first_rise !== 3) begin
            failed++;
            $display("FAIL first_rise: got k=%0d required k=3", first_rise);
        end
        tests_run++;
        if (done_cnt !== 1) begin
            failed++;
            $display("FAIL done_count: got %0d required 1", done_cnt);
        end
        tests_run++;
        if (done_k !== exp_done) begin
            failed++;
            $display("FAIL done_time: got k=%0d required k=%0d", done_k, exp_done);
        end
        tests_run++;
        if (exp_hi.size() != 0 || exp_addr.size() != 0) begin
            failed++;
            $display("FAIL missing_output: %0d bits and %0d reads still expected", exp_hi.size(), exp_addr.size());
        end
        exp_hi.delete();
        exp_addr.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        tests_run++;
        if ({busy_a, done_a, pr_a, led_a, busy_b, led_b} !== 6'b0 || addr_a !== 9'd0) begin
            failed++;
            $display("FAIL reset_values: busy/done/rd/led/busy_b/led_b=%b addr=%0d required 000000 0",
                     {busy_a, done_a, pr_a, led_a, busy_b, led_b}, addr_a);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        tests_run++;
        if ({busy_a, done_a, pr_a, led_a} !== 4'b0) begin
            failed++;
            $display("FAIL idle_after_reset: busy/done/rd/led=%b required 0000", {busy_a, done_a, pr_a, led_a});
        end
    endtask

    task automatic test_frame;
        mem_a[0] = 8'hA5; mem_a[1] = 8'h00; mem_a[2] = 8'hFF; mem_a[3] = 8'hEE;
        push_frame(1'b0);
        watch(1'b0, 240, 1'b0, -1, 1'b0);
    endtask

    task automatic test_start_ignored;
        push_frame(1'b0);
        watch(1'b0, 240, 1'b0, 100, 1'b1);
    endtask

    task automatic test_reset_mid_frame;
        @(negedge clock);
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        repeat (91) @(negedge clock);
        tests_run++;
        if (led_a !== 1'b1 || busy_a !== 1'b1) begin
            failed++;
            $display("FAIL pre_reset_state: led=%b busy=%b required 1 1", led_a, busy_a);
        end
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (led_a !== 1'b0 || busy_a !== 1'b0 || pr_a !== 1'b0) begin
            failed++;
            $display("FAIL async_reset: led=%b busy=%b rd=%b required 0 0 0", led_a, busy_a, pr_a);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            failed++;
            $display("FAIL after_reset: done=%b busy=%b required 0 0", done_a, busy_a);
        end
        push_frame(1'b0);
        watch(1'b0, 240, 1'b0, -1, 1'b0);
    endtask

    task automatic test_single_byte;
        mem_b = 8'h80;
        push_frame(1'b1);
        watch(1'b1, 110, 1'b0, -1, 1'b0);
    endtask

    task automatic test_back_to_back;
        mem_a[0] = 8'hA5; mem_a[1] = 8'h00; mem_a[2] = 8'hFF;
        push_frame(1'b0);
        watch(1'b0, 240, 1'b1, -1, 1'b0);
        mem_a[0] = 8'h3C; mem_a[1] = 8'h81; mem_a[2] = 8'h0F;
        push_frame(1'b0);
        watch(1'b0, 240, 1'b0, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_start_ignored();
        test_reset_mid_frame();
        test_single_byte();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
